// File: rtl/fetch_pipe_ctrl.sv
// Fetch sequencer: owns PC/IR load, stalls on RAW hazards, redirects on branch, drains on HALT.
// Address is registered; strobes are combinational. Define PERF_CNT_EN to add stall/fetch counters.
module fetch_pipe_ctrl #(
  parameter int              ADDR_W    = 8,
  parameter int              REG_W     = 4,
  parameter int              OPC_W     = 5,
  parameter logic [OPC_W-1:0] HALT_OPC = 5'h1F,
  parameter int              DRAIN_CYC = 3,
  parameter int              CNT_W     = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [OPC_W-1:0]  dec_opcode,
  input  logic              dec_valid,
  input  logic [REG_W-1:0]  dec_src1,
  input  logic [REG_W-1:0]  dec_src2,
  input  logic              dec_use1,
  input  logic              dec_use2,
  input  logic [REG_W-1:0]  s1_dest,
  input  logic              s1_wr,
  input  logic [REG_W-1:0]  s2_dest,
  input  logic              s2_wr,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] Address,
  output logic              instRead,
  output logic              bubble,
  output logic              flush,
  output logic              running,
  output logic              halted
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fetch_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, RUN, STALL, FLUSH, DRAIN, HALT} state_t;

  localparam int DC_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DC_W-1:0]   drain_cnt, drain_nxt;
  logic              hazard;
  logic              halt_dec;

  // Stage 3 writes back before decode reads, so only stages 1 and 2 can conflict.
  assign hazard = dec_valid &
                  ((dec_use1 & s1_wr & (dec_src1 == s1_dest)) |
                   (dec_use1 & s2_wr & (dec_src1 == s2_dest)) |
                   (dec_use2 & s1_wr & (dec_src2 == s1_dest)) |
                   (dec_use2 & s2_wr & (dec_src2 == s2_dest)));

  assign halt_dec = dec_valid & (dec_opcode == HALT_OPC);

  always_comb begin
    state_nxt = state;
    addr_nxt  = Address;
    drain_nxt = drain_cnt;
    instRead  = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          addr_nxt  = start_addr;
          state_nxt = RUN;
        end
      end
      // STALL shares RUN's decision: the held IR simply re-decodes each cycle.
      RUN, STALL: begin
        if (br_taken) begin
          addr_nxt  = br_target;
          flush     = 1'b1;
          bubble    = 1'b1;
          state_nxt = FLUSH;
        end else if (halt_dec && !hazard) begin
          bubble    = 1'b1;
          drain_nxt = DC_W'(DRAIN_CYC - 1);
          state_nxt = DRAIN;
        end else if (hazard) begin
          bubble    = 1'b1;
          state_nxt = STALL;
        end else begin
          instRead  = 1'b1;
          addr_nxt  = Address + ADDR_W'(1);
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        instRead  = 1'b1;
        addr_nxt  = Address + ADDR_W'(1);
        state_nxt = RUN;
      end
      DRAIN: begin
        bubble = 1'b1;
        if (drain_cnt == '0) state_nxt = HALT;
        else                 drain_nxt = drain_cnt - DC_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN) || (state == STALL);
  assign halted  = (state == HALT);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Address   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      Address   <= addr_nxt;
      drain_cnt <= drain_nxt;
    end
  end

`ifdef PERF_CNT_EN
  logic start_ok;
  logic stall_evt;

  assign start_ok  = start & ((state == IDLE) || (state == HALT));
  assign stall_evt = running & ~br_taken & hazard;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= '0;
      fetch_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
      fetch_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (instRead && (fetch_cnt != '1))  fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
